mem_arbiter: RTL and testbench

Single-port memory arbiter that shares one unified memory port between the fetch stage (instruction reads) and the mem_branch stage (data loads/stores). Sits between those two pipeline stages and the external memory. It accepts one transaction at a time, registers its payload, issues it to memory, and routes the response back to the owner. Discards fetch responses that a pipeline flush made stale.

---
 rtl/mem_arbiter_pkg.sv | 18 +
 rtl/mem_arb_pick.sv | 48 ++++
 rtl/mem_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_arbiter.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
// Shared encodings for the unified memory-port arbiter.
//   ARB_IDLE / ARB_ISSUE / ARB_WAIT : arbiter FSM state encodings
//   OWN_MB / OWN_IF                 : owner register encodings
//   STARVE_W                        : width of the starvation counter (holds 0..15)
package mem_arbiter_pkg;

  localparam logic [1:0] ARB_IDLE  = 2'd0;
  localparam logic [1:0] ARB_ISSUE = 2'd1;
  localparam logic [1:0] ARB_WAIT  = 2'd2;

  // OWN_MB is the all-zero value so the reset owner falls out naturally.
  localparam logic OWN_MB = 1'b0;
  localparam logic OWN_IF = 1'b1;

  localparam int STARVE_W = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick
// Priority decision between the fetch and data requesters, plus the
// starvation counter that periodically forces a fetch win.
// Ports:
//   clk, rst_n     : clock, synchronous active-low reset
//   if_req, mb_req : pending requests from fetch / data side
//   arb_en         : high only in cycles where a grant may be issued
//   pick_if        : fetch wins this cycle
//   pick_mb        : data side wins this cycle
module mem_arb_pick
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic if_req,
  input  logic mb_req,
  input  logic arb_en,
  output logic pick_if,
  output logic pick_mb
);

  logic [STARVE_W-1:0] starve_cnt;
  logic                starved;

  assign starved = (starve_cnt == STARVE_W'(STARVE_MAX));

  // Data side wins by default; once it has beaten fetch STARVE_MAX times in
  // a row, fetch takes the next contended slot.
  assign pick_if = arb_en && if_req && (!mb_req || starved);
  assign pick_mb = arb_en && mb_req && !(if_req && starved);

  // Counts only contended data wins; any fetch grant or an idle slot without
  // a fetch request means fetch is not being starved, so start over.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (arb_en) begin
      if (pick_if || !if_req) begin
        starve_cnt <= '0;
      end else if (pick_mb) begin
        starve_cnt <= starve_cnt + STARVE_W'(1);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one memory port between instruction fetch and the mem_branch data
// stage. One transaction at a time: grant, register payload, issue to memory,
// route the single response back to its owner. Fetch responses made stale by
// a pipeline flush are swallowed.
// Ports:
//   clk, rst_n                          : clock, synchronous active-low reset
//   if_req/if_addr/if_flush             : fetch read request, pipeline flush
//   if_gnt/if_rvalid/if_rdata           : fetch grant and response
//   mb_req/mb_we/mb_addr/mb_wdata/mb_wstrb : data load/store request
//   mb_gnt/mb_rvalid/mb_rdata           : data grant and response (store ack)
//   mem_req/mem_we/mem_addr/mem_wdata/mem_wstrb : registered memory request
//   mem_gnt/mem_rvalid/mem_rdata        : memory accept and response
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst_n,

  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  input  logic                if_flush,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,

  input  logic                mb_req,
  input  logic                mb_we,
  input  logic [ADDR_W-1:0]   mb_addr,
  input  logic [DATA_W-1:0]   mb_wdata,
  input  logic [DATA_W/8-1:0] mb_wstrb,
  output logic                mb_gnt,
  output logic                mb_rvalid,
  output logic [DATA_W-1:0]   mb_rdata,

  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  logic [1:0] state;
  logic       owner;
  logic       drop;
  logic       arb_en;
  logic       pick_if;
  logic       pick_mb;
  logic       resp_fire;

  // Gating with rst_n keeps both grants low while reset is asserted even
  // though the state register only clears at the edge.
  assign arb_en = rst_n && (state == ARB_IDLE);

  mem_arb_pick #(
    .STARVE_MAX (STARVE_MAX)
  ) u_pick (
    .clk     (clk),
    .rst_n   (rst_n),
    .if_req  (if_req),
    .mb_req  (mb_req),
    .arb_en  (arb_en),
    .pick_if (pick_if),
    .pick_mb (pick_mb)
  );

  assign if_gnt = pick_if;
  assign mb_gnt = pick_mb;

  // A response only counts in WAIT; stray mem_rvalid elsewhere is ignored.
  // A flush arriving together with the response must also kill it, hence
  // the direct if_flush term alongside the registered drop flag.
  assign resp_fire = rst_n && (state == ARB_WAIT) && mem_rvalid;
  assign if_rvalid = resp_fire && (owner == OWN_IF) && !drop && !if_flush;
  assign mb_rvalid = resp_fire && (owner == OWN_MB);
  assign if_rdata  = mem_rdata;
  assign mb_rdata  = mem_rdata;

  // Main FSM: captures the winner's payload, holds it stable on the memory
  // port until accepted, then waits for the single response. The drop flag
  // remembers a flush seen while fetch owns the port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ARB_IDLE;
      owner     <= OWN_MB;
      drop      <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          drop <= 1'b0;
          if (pick_if) begin
            owner     <= OWN_IF;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            drop      <= if_flush;
            state     <= ARB_ISSUE;
          end else if (pick_mb) begin
            owner     <= OWN_MB;
            mem_req   <= 1'b1;
            mem_we    <= mb_we;
            mem_addr  <= mb_addr;
            mem_wdata <= mb_wdata;
            mem_wstrb <= mb_wstrb;
            state     <= ARB_ISSUE;
          end
        end

        ARB_ISSUE: begin
          if ((owner == OWN_IF) && if_flush) begin
            drop <= 1'b1;
          end
          if (mem_gnt) begin
            mem_req <= 1'b0;
            state   <= ARB_WAIT;
          end
        end

        ARB_WAIT: begin
          if ((owner == OWN_IF) && if_flush) begin
            drop <= 1'b1;
          end
          if (mem_rvalid) begin
            drop  <= 1'b0;
            state <= ARB_IDLE;
          end
        end

        default: begin
          mem_req <= 1'b0;
          drop    <= 1'b0;
          state   <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Directed bench for mem_arbiter. Stimulus tasks push the expected grant,
// memory-issue and response events into a queue; a negedge monitor pops and
// compares each event as the DUT presents it.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  localparam int K_GNT_IF = 0;
  localparam int K_GNT_MB = 1;
  localparam int K_ISSUE  = 2;
  localparam int K_RV_IF  = 3;
  localparam int K_RV_MB  = 4;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic        we;
    logic        chk_d;
  } ev_t;

  logic          clk;
  logic          rst_n;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_flush;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          mb_req;
  logic          mb_we;
  logic [AW-1:0] mb_addr;
  logic [DW-1:0] mb_wdata;
  logic [SW-1:0] mb_wstrb;
  logic          mb_gnt;
  logic          mb_rvalid;
  logic [DW-1:0] mb_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [SW-1:0] mem_wstrb;
  logic          mem_gnt;
  logic          mem_rvalid;
  logic [DW-1:0] mem_rdata;

  ev_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;
  logic mem_req_prev = 1'b0;

  mem_arbiter #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .STARVE_MAX (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_flush   (if_flush),
    .if_gnt     (if_gnt),
    .if_rvalid  (if_rvalid),
    .if_rdata   (if_rdata),
    .mb_req     (mb_req),
    .mb_we      (mb_we),
    .mb_addr    (mb_addr),
    .mb_wdata   (mb_wdata),
    .mb_wstrb   (mb_wstrb),
    .mb_gnt     (mb_gnt),
    .mb_rvalid  (mb_rvalid),
    .mb_rdata   (mb_rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic string kname(input int k);
    case (k)
      K_GNT_IF: return "GNT_IF";
      K_GNT_MB: return "GNT_MB";
      K_ISSUE:  return "ISSUE";
      K_RV_IF:  return "RV_IF";
      K_RV_MB:  return "RV_MB";
      default:  return "UNKNOWN";
    endcase
  endfunction

  function automatic void pushEv(input int kind, input logic [31:0] addr,
                                 input logic [31:0] data, input logic [3:0] strb,
                                 input logic we, input logic chk_d);
    ev_t e;
    e.kind  = kind;
    e.addr  = addr;
    e.data  = data;
    e.strb  = strb;
    e.we    = we;
    e.chk_d = chk_d;
    exp_q.push_back(e);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  // Scoreboard side: compare one observed DUT event against the queue head.
  task automatic observe(input int kind, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] strb,
                         input logic we);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("[TB] FAIL unexpected_event: got %s at %0t expected none pending",
               kname(kind), $time);
      return;
    end
    e = exp_q.pop_front();
    if (e.kind != kind) begin
      failures++;
      $display("[TB] FAIL event_order: got %s expected %s at %0t",
               kname(kind), kname(e.kind), $time);
      return;
    end
    if (kind == K_ISSUE) begin
      checkOutput("issue_mem_addr", addr, e.addr);
      checkOutput("issue_mem_we", 32'(we), 32'(e.we));
      checkOutput("issue_mem_wstrb", 32'(strb), 32'(e.strb));
      if (e.we) checkOutput("issue_mem_wdata", data, e.data);
    end
    if ((kind == K_RV_IF || kind == K_RV_MB) && e.chk_d) begin
      checkOutput("resp_rdata", data, e.data);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (if_gnt)    observe(K_GNT_IF, if_addr, 32'h0, 4'h0, 1'b0);
    if (mb_gnt)    observe(K_GNT_MB, mb_addr, 32'h0, 4'h0, 1'b0);
    if (mem_req && !mem_req_prev)
                   observe(K_ISSUE, mem_addr, mem_wdata, mem_wstrb, mem_we);
    if (if_rvalid) observe(K_RV_IF, 32'h0, if_rdata, 4'h0, 1'b0);
    if (mb_rvalid) observe(K_RV_MB, 32'h0, mb_rdata, 4'h0, 1'b0);
    mem_req_prev = mem_req;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives the memory side from the first ISSUE cycle to the response cycle.
  // flush_mode: 0 none, 1 flush in last WAIT cycle before rvalid,
  // 2 flush coincident with rvalid, 3 flush in the granting IDLE cycle.
  task automatic memHandshake(input int gnt_wait, input int rv_wait,
                              input logic [31:0] rdata, input int flush_mode,
                              input logic is_if, input logic [31:0] addr,
                              input logic chk_d);
    for (int i = 0; i < gnt_wait; i++) begin
      if (is_if) begin
        if_req  = 1'b1;
        if_addr = addr ^ (32'(i + 1) << 8);
      end
      #1;
      checkOutput("bp_mem_req", 32'(mem_req), 32'h1);
      checkOutput("bp_mem_addr", mem_addr, addr);
      tick();
    end
    if (is_if) if_req = 1'b0;
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    for (int i = 0; i < rv_wait; i++) begin
      checkOutput("wait_mem_req", 32'(mem_req), 32'h0);
      if (flush_mode == 1 && i == rv_wait - 1) if_flush = 1'b1;
      tick();
      if_flush = 1'b0;
    end
    mem_rvalid = 1'b1;
    mem_rdata  = rdata;
    if (flush_mode == 2) if_flush = 1'b1;
    if (!is_if || flush_mode == 0) begin
      pushEv(is_if ? K_RV_IF : K_RV_MB, 32'h0, rdata, 4'h0, 1'b0, chk_d);
    end
    tick();
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    if_flush   = 1'b0;
  endtask

  // One complete transaction started from IDLE by a single requester.
  task automatic applyStimulus(input logic is_if, input logic we,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] strb, input int gnt_wait,
                               input int rv_wait, input logic [31:0] rdata,
                               input int flush_mode);
    if (is_if) begin
      if_req  = 1'b1;
      if_addr = addr;
      if (flush_mode == 3) if_flush = 1'b1;
      pushEv(K_GNT_IF, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
      pushEv(K_ISSUE, addr, 32'h0, 4'h0, 1'b0, 1'b0);
    end else begin
      mb_req   = 1'b1;
      mb_we    = we;
      mb_addr  = addr;
      mb_wdata = wdata;
      mb_wstrb = strb;
      pushEv(K_GNT_MB, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
      pushEv(K_ISSUE, addr, wdata, strb, we, 1'b0);
    end
    tick();
    if_req   = 1'b0;
    if_flush = 1'b0;
    mb_req   = 1'b0;
    mb_addr  = 32'hBAD0_0000;
    mb_wdata = 32'hFFFF_FFFF;
    memHandshake(gnt_wait, rv_wait, rdata, flush_mode, is_if, addr, !we);
  endtask

  initial begin
    logic [9:0] starve_pat;
    logic       win_if;
    starve_pat = 10'b10_0001_0000;

    rst_n      = 1'b0;
    if_req     = 1'b1;
    if_addr    = 32'h0000_0040;
    if_flush   = 1'b0;
    mb_req     = 1'b1;
    mb_we      = 1'b1;
    mb_addr    = 32'h0000_0080;
    mb_wdata   = 32'h1234_5678;
    mb_wstrb   = 4'hF;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hFFFF_FFFF;

    // Reset state, with both requests and a stray response present.
    repeat (3) tick();
    checkOutput("rst_if_gnt", 32'(if_gnt), 32'h0);
    checkOutput("rst_mb_gnt", 32'(mb_gnt), 32'h0);
    checkOutput("rst_mem_req", 32'(mem_req), 32'h0);
    checkOutput("rst_mem_we", 32'(mem_we), 32'h0);
    checkOutput("rst_mem_addr", mem_addr, 32'h0);
    checkOutput("rst_mem_wdata", mem_wdata, 32'h0);
    checkOutput("rst_mem_wstrb", 32'(mem_wstrb), 32'h0);
    checkOutput("rst_if_rvalid", 32'(if_rvalid), 32'h0);
    checkOutput("rst_mb_rvalid", 32'(mb_rvalid), 32'h0);

    if_req     = 1'b0;
    mb_req     = 1'b0;
    mb_we      = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    rst_n      = 1'b1;
    tick();

    // Lone fetch: gnt@0, mem_req@1 addr 0x100, rvalid@3 with 0x13, IDLE@4.
    applyStimulus(1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'h0, 0, 1, 32'h0000_0013, 0);
    checkOutput("idle_after_fetch_mem_req", 32'(mem_req), 32'h0);

    // Contention: MB store wins, IF held and granted at the next IDLE.
    if_req   = 1'b1;
    if_addr  = 32'h0000_0300;
    mb_req   = 1'b1;
    mb_we    = 1'b1;
    mb_addr  = 32'h0000_2000;
    mb_wdata = 32'hDEAD_BEEF;
    mb_wstrb = 4'hF;
    pushEv(K_GNT_MB, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
    pushEv(K_ISSUE, 32'h0000_2000, 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b0);
    tick();
    mb_req = 1'b0;
    memHandshake(0, 0, 32'h0, 0, 1'b0, 32'h0000_2000, 1'b0);
    pushEv(K_GNT_IF, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
    pushEv(K_ISSUE, 32'h0000_0300, 32'h0, 4'h0, 1'b0, 1'b0);
    tick();
    if_req = 1'b0;
    memHandshake(0, 0, 32'h1111_1111, 0, 1'b1, 32'h0000_0300, 1'b1);

    // Starvation: both held, expected winners MB,MB,MB,MB,IF twice.
    for (int k = 0; k < 10; k++) begin
      if_req   = 1'b1;
      if_addr  = 32'h0000_0500;
      mb_req   = 1'b1;
      mb_we    = 1'b0;
      mb_addr  = 32'h0000_4000;
      mb_wdata = 32'h0;
      mb_wstrb = 4'h0;
      win_if   = starve_pat[k];
      if (win_if) begin
        pushEv(K_GNT_IF, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
        pushEv(K_ISSUE, 32'h0000_0500, 32'h0, 4'h0, 1'b0, 1'b0);
      end else begin
        pushEv(K_GNT_MB, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
        pushEv(K_ISSUE, 32'h0000_4000, 32'h0, 4'h0, 1'b0, 1'b0);
      end
      tick();
      memHandshake(0, 0, 32'h0000_00A0 + 32'(k), 0, win_if,
                   win_if ? 32'h0000_0500 : 32'h0000_4000, 1'b1);
    end
    if_req = 1'b0;
    mb_req = 1'b0;
    tick();

    // Flush cases: before rvalid, coincident, at grant; then normal fetches.
    applyStimulus(1'b1, 1'b0, 32'h0000_0180, 32'h0, 4'h0, 0, 2, 32'h0000_0055, 1);
    applyStimulus(1'b1, 1'b0, 32'h0000_01C0, 32'h0, 4'h0, 0, 1, 32'h0000_0066, 2);
    applyStimulus(1'b1, 1'b0, 32'h0000_01E0, 32'h0, 4'h0, 0, 1, 32'h0000_0077, 3);
    if_flush = 1'b1;
    tick();
    if_flush = 1'b0;
    applyStimulus(1'b1, 1'b0, 32'h0000_0200, 32'h0, 4'h0, 0, 1, 32'h0020_0093, 0);
    applyStimulus(1'b0, 1'b0, 32'h0000_3000, 32'h0, 4'h0, 0, 1, 32'h1234_5678, 2);

    // Backpressure: mem_gnt low 5 ISSUE cycles while if_req/if_addr churn.
    applyStimulus(1'b1, 1'b0, 32'h0000_0600, 32'h0, 4'h0, 5, 1, 32'h0000_0088, 0);
    applyStimulus(1'b0, 1'b1, 32'h0000_2100, 32'hA5A5_5A5A, 4'h6, 2, 1, 32'h0, 0);

    // Reset mid-WAIT, then a late mem_rvalid and a fresh data request.
    mb_req   = 1'b1;
    mb_we    = 1'b1;
    mb_addr  = 32'h0000_2400;
    mb_wdata = 32'h0BAD_F00D;
    mb_wstrb = 4'h3;
    pushEv(K_GNT_MB, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
    pushEv(K_ISSUE, 32'h0000_2400, 32'h0BAD_F00D, 4'h3, 1'b1, 1'b0);
    tick();
    mb_req  = 1'b0;
    mem_gnt = 1'b1;
    tick();
    mem_gnt  = 1'b0;
    rst_n    = 1'b0;
    mb_req   = 1'b1;
    mb_we    = 1'b0;
    mb_addr  = 32'h0000_7000;
    mb_wdata = 32'h0;
    mb_wstrb = 4'h0;
    #1;
    checkOutput("rstw_mb_gnt", 32'(mb_gnt), 32'h0);
    tick();
    rst_n      = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hFFFF_0000;
    pushEv(K_GNT_MB, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
    pushEv(K_ISSUE, 32'h0000_7000, 32'h0, 4'h0, 1'b0, 1'b0);
    #1;
    checkOutput("rstw_mem_req", 32'(mem_req), 32'h0);
    checkOutput("rstw_mem_addr", mem_addr, 32'h0);
    checkOutput("rstw_mem_wdata", mem_wdata, 32'h0);
    checkOutput("rstw_mem_wstrb", 32'(mem_wstrb), 32'h0);
    checkOutput("rstw_mem_we", 32'(mem_we), 32'h0);
    checkOutput("rstw_mb_rvalid", 32'(mb_rvalid), 32'h0);
    checkOutput("rstw_if_rvalid", 32'(if_rvalid), 32'h0);
    checkOutput("rstw_fresh_mb_gnt", 32'(mb_gnt), 32'h1);
    tick();
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    mb_req     = 1'b0;
    memHandshake(0, 1, 32'hCAFE_F00D, 0, 1'b0, 32'h0000_7000, 1'b1);

    repeat (3) tick();
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("[TB] FAIL watchdog: got timeout at %0t expected completion", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
